// File: rtl/ece552_pkg.sv
// ---------------------------------------------------------------------------
// ece552_pkg
//   Shared types and constants for the execute/memory pipeline register.
//   - ex_mem_ctrl_t    : 7-bit control bundle, same bit order as in_ctrl
//                        {halt,memwrt,memrd,brchcnd,alujmp,setrd,regsrc}
//   - ex_mem_payload_t : one held entry (four DATA_W fields + ctrl), packed
//                        in the same order the pipe concatenates its ports
//   - ST_*             : occupancy state encoding of ex_mem_pipe
//   - mask_mem_ctrl    : zeroes the memory-side strobes of an invalid head
// ---------------------------------------------------------------------------
package ece552_pkg;

  localparam int EX_MEM_DATA_W = 16;
  localparam int CTRL_W        = 7;

  typedef struct packed {
    logic halt;
    logic memwrt;
    logic memrd;
    logic brchcnd;
    logic alujmp;
    logic setrd;
    logic regsrc;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [EX_MEM_DATA_W-1:0] alu_result;
    logic [EX_MEM_DATA_W-1:0] wr_data;
    logic [EX_MEM_DATA_W-1:0] pc;
    logic [EX_MEM_DATA_W-1:0] jmp_offset;
    ex_mem_ctrl_t             ctrl;
  } ex_mem_payload_t;

  // Occupancy of the two-slot buffer.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [15:0] PERF_SAT = 16'hFFFF;

  // A memory stage must never see a store/load strobe from a slot that is
  // not presenting a valid instruction.
  function automatic ex_mem_ctrl_t mask_mem_ctrl(input ex_mem_ctrl_t c,
                                                 input logic         valid);
    ex_mem_ctrl_t m;
    m        = c;
    m.memwrt = c.memwrt & valid;
    m.memrd  = c.memrd & valid;
    return m;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
//   One payload register of the ex_mem skid buffer.
//   Ports:
//     clk   : clock, rising edge
//     rst   : asynchronous, active-low reset (clears the slot)
//     load  : capture d at the next edge
//     clear : zero the slot at the next edge (wins over load)
//     d     : payload to capture
//     q     : held payload
// ---------------------------------------------------------------------------
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= '0;
    end else if (clear) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/ex_mem_pipe.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe
//   Execute -> memory pipeline register with a valid/ready handshake and a
//   two-entry skid buffer (head slot + skid slot), flush and sticky halt.
//   Ports:
//     clk, rst                      : clock, async active-low reset
//     in_valid / in_ready           : execute-side handshake
//     in_alu_result, in_wr_data,
//     in_pc, in_jmp_offset, in_ctrl : execute-side payload
//     flush                         : drop every held entry at the next edge
//     out_valid / out_ready         : memory-side handshake
//     out_alu_result, out_wr_data,
//     out_pc, out_jmp_offset        : head payload (zero when empty)
//     out_ctrl                      : head ctrl, memwrt/memrd masked by out_valid
//     halted                        : sticky, set when a halt entry is consumed
//   Build option EX_MEM_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
// ---------------------------------------------------------------------------
module ex_mem_pipe
  import ece552_pkg::*;
#(
  parameter int DATA_W = EX_MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_wr_data,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_jmp_offset,
  input  logic [6:0]        in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_wr_data,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_jmp_offset,
  output logic [6:0]        out_ctrl,
  output logic              halted
`ifdef EX_MEM_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam int PAY_W = 4 * DATA_W + CTRL_W;

  logic [1:0]       state_reg, state_next;
  logic             halted_reg, halted_next;
  logic             accept, consume;
  logic             head_from_skid;
  logic [1:0]       slot_load, slot_clr;   // index 0 = head, 1 = skid
  logic [PAY_W-1:0] slot_d [2];
  logic [PAY_W-1:0] slot_q [2];
  logic [PAY_W-1:0] in_payload;
  ex_mem_ctrl_t     head_ctrl;

  assign in_payload = {in_alu_result, in_wr_data, in_pc, in_jmp_offset, in_ctrl};

  // Handshake status comes only from registers, so in_ready never depends
  // combinationally on out_ready.
  assign out_valid = (state_reg != ST_EMPTY);
  assign in_ready  = (state_reg != ST_TWO) && !halted_reg;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_EMPTY;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      halted_reg <= halted_next;
    end
  end

  // Next-state logic. Flush overrides every transfer; a consume in the
  // flush cycle still counts for halt.
  always_comb begin
    state_next  = state_reg;
    halted_next = halted_reg | (consume & head_ctrl.halt);
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: if (accept) state_next = ST_ONE;
        ST_ONE: begin
          if (accept && !consume)      state_next = ST_TWO;
          else if (!accept && consume) state_next = ST_EMPTY;
        end
        ST_TWO:   if (consume) state_next = ST_ONE;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  // Slot control. Slots that are not occupied are kept at zero so that an
  // empty pipe presents all-zero payload outputs.
  always_comb begin
    slot_load      = 2'b00;
    slot_clr       = 2'b00;
    head_from_skid = 1'b0;
    if (flush) begin
      slot_clr = 2'b11;
    end else begin
      case (state_reg)
        ST_EMPTY: if (accept) slot_load[0] = 1'b1;
        ST_ONE: begin
          if (accept && consume)  slot_load[0] = 1'b1;
          else if (accept)        slot_load[1] = 1'b1;
          else if (consume)       slot_clr[0]  = 1'b1;
        end
        ST_TWO: begin
          if (consume) begin
            slot_load[0]   = 1'b1;
            head_from_skid = 1'b1;
            slot_clr[1]    = 1'b1;
          end
        end
        default: slot_clr = 2'b11;
      endcase
    end
  end

  assign slot_d[0] = head_from_skid ? slot_q[1] : in_payload;
  assign slot_d[1] = in_payload;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      pipe_slot #(.W(PAY_W)) u_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (slot_load[gi]),
        .clear (slot_clr[gi]),
        .d     (slot_d[gi]),
        .q     (slot_q[gi])
      );
    end
  endgenerate

  assign {out_alu_result, out_wr_data, out_pc, out_jmp_offset} = slot_q[0][PAY_W-1:CTRL_W];
  assign head_ctrl = slot_q[0][CTRL_W-1:0];
  assign out_ctrl  = mask_mem_ctrl(head_ctrl, out_valid);
  assign halted    = halted_reg;

`ifdef EX_MEM_PERF_EN
  logic [15:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_reg != PERF_SAT))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (flush && (state_reg != ST_EMPTY) && (flush_cnt_reg != PERF_SAT))
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_pipe
//   Self-checking bench for ex_mem_pipe. The reference is a plain FIFO queue
//   of at most two payloads plus a halted bit; expected outputs are the queue
//   head (or zero) and status derived from the queue length.
//   Define EX_MEM_PERF_EN to also exercise stall_cnt / flush_cnt.
// ---------------------------------------------------------------------------
module tb_ex_mem_pipe;
  import ece552_pkg::*;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, in_valid, out_ready, flush;
  ex_mem_payload_t drv;
  logic            in_ready, out_valid, halted;
  logic [DW-1:0]   out_alu_result, out_wr_data, out_pc, out_jmp_offset;
  logic [6:0]      out_ctrl;
`ifdef EX_MEM_PERF_EN
  logic [15:0]     stall_cnt, flush_cnt;
`endif

  ex_mem_pipe #(.DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_result  (drv.alu_result),
    .in_wr_data     (drv.wr_data),
    .in_pc          (drv.pc),
    .in_jmp_offset  (drv.jmp_offset),
    .in_ctrl        (drv.ctrl),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu_result (out_alu_result),
    .out_wr_data    (out_wr_data),
    .out_pc         (out_pc),
    .out_jmp_offset (out_jmp_offset),
    .out_ctrl       (out_ctrl),
    .halted         (halted)
`ifdef EX_MEM_PERF_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  // Reference model state.
  ex_mem_payload_t mq[$];
  bit              m_halted;
  logic [15:0]     m_stall, m_flush;
  int              checks, failures, cyc;

  logic [73:0] dut_obs;
  assign dut_obs = {halted, in_ready, out_valid, out_alu_result, out_wr_data,
                    out_pc, out_jmp_offset, out_ctrl};

  function automatic logic [73:0] exp_obs();
    ex_mem_payload_t h;
    logic            ov, ir;
    h  = '0;
    ov = (mq.size() > 0);
    ir = (mq.size() < 2) && !m_halted;
    if (ov) h = mq[0];
    return {m_halted, ir, ov, h};
  endfunction

  function automatic ex_mem_payload_t rand_payload(input logic halt);
    ex_mem_payload_t p;
    logic [31:0]     r;
    r = $urandom; p.alu_result = r[15:0]; p.wr_data    = r[31:16];
    r = $urandom; p.pc         = r[15:0]; p.jmp_offset = r[31:16];
    r = $urandom; p.ctrl       = {halt, r[5:0]};
    return p;
  endfunction

  // Advance one clock edge and apply the FIFO rules to the model using the
  // inputs that were present before the edge.
  task automatic cycle();
    logic            ov, ir, acc, con, stl, fne;
    ex_mem_payload_t p;
    ov  = (mq.size() > 0);
    ir  = (mq.size() < 2) && !m_halted;
    acc = in_valid && ir;
    con = ov && out_ready;
    stl = ov && !out_ready;
    fne = flush && ov;
    p   = drv;
    @(posedge clk);
    #1;
    if (con) begin
      if (mq[0].ctrl.halt) m_halted = 1'b1;
      void'(mq.pop_front());
    end
    if (flush) mq.delete();
    else if (acc) mq.push_back(p);
    if (stl && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (fne && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; drv = '0;
    #2;
    mq.delete(); m_halted = 1'b0; m_stall = '0; m_flush = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; drv = '0;
    mq.delete(); m_halted = 1'b0; m_stall = '0; m_flush = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_obs !== exp_obs()) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", dut_obs, exp_obs());
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_stream();
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < 5) begin
        drv = rand_payload(1'b0);
        drv.alu_result = 16'h0010;
      end else begin
        in_valid = 1'b0;
      end
      checks++;
      if (dut_obs !== exp_obs()) begin
        failures++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, dut_obs, exp_obs());
      end
      if (i >= 1 && i <= 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_alu_result !== 16'h0010) begin
          failures++; $display("FAIL stream_out i=%0d got valid=%b alu=%h exp valid=1 alu=0010", i, out_valid, out_alu_result);
        end
      end
      cycle();
    end
  endtask

  task automatic test_skid();
    ex_mem_payload_t pa, pb, pcc;
    logic [15:0]     got[$];
    bit              c_acc;
    pa = rand_payload(1'b0);  pa.alu_result  = 16'h00A0;
    pb = rand_payload(1'b0);  pb.alu_result  = 16'h00B0;
    pcc = rand_payload(1'b0); pcc.alu_result = 16'h00C0;
    c_acc = 1'b0; out_ready = 1'b0; flush = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = !c_acc;
      drv = (i == 0) ? pa : (i == 1) ? pb : pcc;
      if (i >= 5) out_ready = 1'b1;
      checks++;
      if (dut_obs !== exp_obs()) begin
        failures++; $display("FAIL skid cyc=%0d got=%h exp=%h", cyc, dut_obs, exp_obs());
      end
      if (i >= 2 && i <= 4) begin
        checks++;
        if (in_ready !== 1'b0 || out_alu_result !== 16'h00A0) begin
          failures++; $display("FAIL skid_hold i=%0d got ready=%b alu=%h exp ready=0 alu=00a0", i, in_ready, out_alu_result);
        end
      end
      if (out_valid && out_ready) got.push_back(out_alu_result);
      if (i >= 2 && in_valid && mq.size() < 2 && !m_halted) c_acc = 1'b1;
      cycle();
    end
    checks++;
    if (got.size() != 3 || got[0] !== 16'h00A0 || got[1] !== 16'h00B0 || got[2] !== 16'h00C0) begin
      failures++; $display("FAIL skid_order got n=%0d exp n=3 order A,B,C", got.size());
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drv = rand_payload(1'b0);
      cycle();
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL flush_pre_two got ready=%b valid=%b exp ready=0 valid=1", in_ready, out_valid);
    end
    drv = rand_payload(1'b0); drv.alu_result = 16'hDEAD;
    flush = 1'b1; out_ready = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_two got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    // Flush from ONE with an acceptable offer: the offer must be dropped.
    in_valid = 1'b1; out_ready = 1'b0; drv = rand_payload(1'b0);
    cycle();
    drv = rand_payload(1'b0); flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut_obs !== exp_obs()) begin
        failures++; $display("FAIL flush_after cyc=%0d got=%h exp=%h", cyc, dut_obs, exp_obs());
      end
      cycle();
    end
  endtask

  task automatic test_memwrt();
    flush = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      drv = rand_payload(1'b0);
      drv.ctrl.memwrt = 1'b1;
      drv.ctrl.memrd  = 1'b1;
      checks++;
      if (dut_obs !== exp_obs()) begin
        failures++; $display("FAIL memwrt cyc=%0d got=%h exp=%h", cyc, dut_obs, exp_obs());
      end
      if (mq.size() == 0) begin
        checks++;
        if (out_ctrl[5:4] !== 2'b00) begin
          failures++; $display("FAIL memwrt_mask cyc=%0d got=%b exp=00", cyc, out_ctrl[5:4]);
        end
      end
      cycle();
    end
  endtask

  task automatic test_halt();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    out_ready = 1'b0; in_valid = 1'b1;
    drv = rand_payload(1'b0); drv.ctrl = 7'b1000000;
    cycle();
    drv = rand_payload(1'b0);
    cycle();
    drv = rand_payload(1'b0); out_ready = 1'b1;
    cycle();
    checks++;
    if (halted !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL halt_set got halted=%b ready=%b exp halted=1 ready=0", halted, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_obs !== exp_obs()) begin
        failures++; $display("FAIL halt_drain cyc=%0d got=%h exp=%h", cyc, dut_obs, exp_obs());
      end
      cycle();
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++;
    if (halted !== 1'b1) begin
      failures++; $display("FAIL halt_flush got=%b exp=1", halted);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0) begin
      failures++; $display("FAIL halt_rst got=%b exp=0", halted);
    end
    mq.delete(); m_halted = 1'b0; m_stall = '0; m_flush = '0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drv = rand_payload(1'b1);
      cycle();
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_alu_result !== 16'h0000 || out_ctrl !== 7'h00) begin
      failures++; $display("FAIL async_rst got valid=%b alu=%h ctrl=%h exp all 0", out_valid, out_alu_result, out_ctrl);
    end
    mq.delete(); m_halted = 1'b0; m_stall = '0; m_flush = '0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (dut_obs !== exp_obs()) begin
      failures++; $display("FAIL async_rst_release got=%h exp=%h", dut_obs, exp_obs());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (m_halted && mq.size() == 0) do_reset();
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 15) == 0);
      drv = rand_payload(1'($urandom_range(0, 49) == 0));
      checks++;
      if (dut_obs !== exp_obs()) begin
        failures++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_obs, exp_obs());
      end
      cycle();
    end
    flush = 1'b0;
  endtask

`ifdef EX_MEM_PERF_EN
  task automatic test_perf();
    do_reset();
    in_valid = 1'b1; drv = rand_payload(1'b0);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (stall_cnt !== 16'd4) begin
      failures++; $display("FAIL perf_stall4 got=%0d exp=4", stall_cnt);
    end
    for (int i = 0; i < 65530; i++) cycle();
    checks++;
    if (stall_cnt !== 16'hFFFE || stall_cnt !== m_stall) begin
      failures++; $display("FAIL perf_stall_fffe got=%h exp=fffe", stall_cnt);
    end
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      failures++; $display("FAIL perf_stall_sat got=%h exp=ffff", stall_cnt);
    end
    flush = 1'b1;
    cycle();
    cycle();
    flush = 1'b0;
    checks++;
    if (flush_cnt !== 16'd1 || flush_cnt !== m_flush) begin
      failures++; $display("FAIL perf_flush got=%0d exp=1", flush_cnt);
    end
  endtask
`endif

  initial begin
    checks = 0; failures = 0; cyc = 0;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_memwrt();
    test_halt();
    test_reset_mid();
    test_random();
`ifdef EX_MEM_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
